// File: rtl/pool1_window_buffer.sv
// Ping-pong window buffer between conv layer 1 and maxpooling layer 1.
// Packs POOL consecutive 4-channel sample sets into one window per bank and hands windows out oldest first.
module pool1_window_buffer #(
  parameter int             DW      = 8,
  parameter int             POOL    = 5,
  parameter logic [DW-1:0]  PAD_VAL = '0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic                         in_last,
  input  logic signed [DW-1:0]         in_ch1,
  input  logic signed [DW-1:0]         in_ch2,
  input  logic signed [DW-1:0]         in_ch3,
  input  logic signed [DW-1:0]         in_ch4,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic                         out_last,
  output logic [2:0]                   out_cnt,
  output logic [POOL-1:0][DW-1:0]      win1,
  output logic [POOL-1:0][DW-1:0]      win2,
  output logic [POOL-1:0][DW-1:0]      win3,
  output logic [POOL-1:0][DW-1:0]      win4
);

  localparam int IW = (POOL > 1) ? $clog2(POOL) : 1;

  typedef enum logic [1:0] {EMPTY = 2'd0, FILLING = 2'd1, FULL = 2'd2} bank_st_e;
  typedef logic [POOL-1:0][DW-1:0] win_t;

  bank_st_e      st_q [2];
  bank_st_e      st_d [2];
  logic          fb_q, fb_d;
  logic          ob_q, ob_d;
  logic [IW-1:0] idx_q, idx_d;

  win_t          bank_q [2][4];
  win_t          bank_d [2][4];
  logic [2:0]    bcnt_q [2];
  logic [2:0]    bcnt_d [2];
  logic          blast_q [2];
  logic          blast_d [2];

  win_t          win_q [4];
  win_t          win_d [4];
  logic [2:0]    cnt_q, cnt_d;
  logic          last_q, last_d;

  logic [DW-1:0] ch_in [4];
  win_t          close_win [4];
  logic [2:0]    close_cnt;
  logic          acc, close, rel, present;

  assign ch_in[0] = in_ch1;
  assign ch_in[1] = in_ch2;
  assign ch_in[2] = in_ch3;
  assign ch_in[3] = in_ch4;

  assign in_ready  = (st_q[fb_q] != FULL);
  assign out_valid = (st_q[ob_q] == FULL);
  assign acc       = in_valid & in_ready;
  assign close     = acc & ((idx_q == IW'(POOL - 1)) | in_last);
  assign rel       = out_valid & out_ready;
  assign close_cnt = 3'(idx_q) + 3'd1;

  // Window as it will look once the current accept closes it: stored slots, new sample, then padding.
  always_comb begin
    for (int c = 0; c < 4; c++) begin
      for (int s = 0; s < POOL; s++) begin
        if (s < int'(idx_q))       close_win[c][s] = bank_q[fb_q][c][s];
        else if (s == int'(idx_q)) close_win[c][s] = ch_in[c];
        else                       close_win[c][s] = PAD_VAL;
      end
    end
  end

  always_comb begin
    bank_d  = bank_q;
    bcnt_d  = bcnt_q;
    blast_d = blast_q;
    if (close) begin
      for (int c = 0; c < 4; c++) bank_d[fb_q][c] = close_win[c];
      bcnt_d[fb_q]  = close_cnt;
      blast_d[fb_q] = in_last;
    end else if (acc) begin
      for (int c = 0; c < 4; c++) bank_d[fb_q][c][idx_q] = ch_in[c];
    end
  end

  always_comb begin
    st_d  = st_q;
    idx_d = idx_q;
    fb_d  = fb_q ^ close;
    ob_d  = ob_q ^ rel;
    if (acc) begin
      st_d[fb_q] = close ? FULL : FILLING;
      idx_d      = close ? '0 : idx_q + IW'(1);
    end
    if (rel) st_d[ob_q] = EMPTY;

    // Reload the output registers whenever a new window becomes the presented one.
    win_d   = win_q;
    cnt_d   = cnt_q;
    last_d  = last_q;
    present = (st_d[ob_d] == FULL) && (rel || !out_valid);
    if (present) begin
      if (st_q[ob_d] == FULL) begin
        win_d  = bank_q[ob_d];
        cnt_d  = bcnt_q[ob_d];
        last_d = blast_q[ob_d];
      end else begin
        win_d  = close_win;
        cnt_d  = close_cnt;
        last_d = in_last;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
      fb_q    <= 1'b0;
      ob_q    <= 1'b0;
      idx_q   <= '0;
      cnt_q   <= '0;
      last_q  <= 1'b0;
      for (int c = 0; c < 4; c++) win_q[c] <= '0;
    end else begin
      st_q   <= st_d;
      fb_q   <= fb_d;
      ob_q   <= ob_d;
      idx_q  <= idx_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
      win_q  <= win_d;
    end
  end

  // Bank contents are only meaningful under the bank state, so they carry no reset.
  always_ff @(posedge clk) begin
    bank_q  <= bank_d;
    bcnt_q  <= bcnt_d;
    blast_q <= blast_d;
  end

  assign out_cnt  = cnt_q;
  assign out_last = last_q;
  assign win1     = win_q[0];
  assign win2     = win_q[1];
  assign win3     = win_q[2];
  assign win4     = win_q[3];

endmodule
